// File: rtl/wb_cmd_master.sv
// Wishbone pipelined-mode initiator: one bus cycle per command from a valid/ready
// command port, with read data or a timeout error returned on a valid/ready response port.
module wb_cmd_master #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                o_wb_cyc,
  output logic                o_wb_stb,
  output logic                o_wb_we,
  output logic [DATA_W/8-1:0] o_wb_sel,
  output logic [ADDR_W-1:0]   o_wb_addr,
  output logic [DATA_W-1:0]   o_wb_data,
  input  logic                i_wb_ack,
  input  logic                i_wb_stall,
  input  logic [DATA_W-1:0]   i_wb_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [15:0]         tmo_q, tmo_d;
  logic                expire;
  logic                bus_active;

  assign expire = (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // An ack in the expiry cycle completes normally; an ack while stalled in REQ is ignored.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_REQ;
          we_d    = cmd_we;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          tmo_d   = '0;
        end
      end
      S_REQ: begin
        tmo_d = tmo_q + 16'd1;
        if (!i_wb_stall && i_wb_ack) begin
          state_d = S_RESP;
          rdata_d = we_q ? '0 : i_wb_data;
          err_d   = 1'b0;
        end else if (expire) begin
          state_d = S_RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end else if (!i_wb_stall) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + 16'd1;
        if (i_wb_ack) begin
          state_d = S_RESP;
          rdata_d = we_q ? '0 : i_wb_data;
          err_d   = 1'b0;
        end else if (expire) begin
          state_d = S_RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from the state register so reset clears them asynchronously.
  assign bus_active = (state_q == S_REQ) || (state_q == S_WAIT);
  assign cmd_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;
  assign o_wb_cyc   = bus_active;
  assign o_wb_stb   = (state_q == S_REQ);
  assign o_wb_we    = bus_active & we_q;
  assign o_wb_sel   = bus_active ? '1 : '0;
  assign o_wb_addr  = bus_active ? addr_q : '0;
  assign o_wb_data  = bus_active ? wdata_q : '0;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed cases plus randomized transactions
// checked against a per-transaction outcome model computed from stall/ack timing.
module tb_wb_cmd_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_wb_addr, o_wb_data;
  logic        i_wb_ack, i_wb_stall;
  logic [31:0] i_wb_data;

  int n_checks = 0;
  int n_errors = 0;

  wb_cmd_master #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .o_wb_cyc   (o_wb_cyc),
    .o_wb_stb   (o_wb_stb),
    .o_wb_we    (o_wb_we),
    .o_wb_sel   (o_wb_sel),
    .o_wb_addr  (o_wb_addr),
    .o_wb_data  (o_wb_data),
    .i_wb_ack   (i_wb_ack),
    .i_wb_stall (i_wb_stall),
    .i_wb_data  (i_wb_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One command; the slave stalls s cycles, then acks d cycles after acceptance
  // (d=0: same cycle). Outcome predicted from cycle arithmetic against TMO.
  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rd, input int s, input int d,
                         input bit has_ack, input int r);
    int k, c, exp_cyc, exp_stb, cyc_n, stb_n, lat;
    bit tmo;
    logic [31:0] exp_rd;
    k       = s + 1;
    c       = k + d;
    tmo     = !has_ack || (c > TMO);
    exp_cyc = tmo ? TMO : c;
    exp_stb = (k < TMO) ? k : TMO;
    exp_rd  = (tmo || we) ? 32'h0 : rd;

    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_we    = ~we;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cyc_n = 0;
    stb_n = 0;
    lat   = 0;
    for (int j = 1; j <= TMO + 10; j++) begin
      if (rsp_valid) begin
        lat = j;
        break;
      end
      if (o_wb_cyc) begin
        cyc_n++;
        if (o_wb_stb) stb_n++;
        check("wb_addr", o_wb_addr, addr);
        check("wb_data", o_wb_data, wdata);
        check("wb_we", o_wb_we, we);
        check("wb_sel", o_wb_sel, 4'hF);
        check("cmd_ready_busy", cmd_ready, 0);
        i_wb_stall = (j <= s);
        i_wb_ack   = (has_ack && j == c) || (j <= s && $urandom_range(0, 1) == 1);
        i_wb_data  = (j == c) ? rd : $urandom;
      end else begin
        i_wb_stall = 1'b0;
        i_wb_ack   = 1'b0;
      end
      @(negedge clk);
    end
    check("rsp_seen", lat != 0, 1);
    check("rsp_latency", lat, exp_cyc + 1);
    check("cyc_cycles", cyc_n, exp_cyc);
    check("stb_cycles", stb_n, exp_stb);
    check("rsp_err", rsp_err, tmo);
    check("rsp_rdata", rsp_rdata, exp_rd);

    // Backpressure, with stray acks and a pending command that must not be taken.
    i_wb_stall = 1'b0;
    for (int i = 0; i < r; i++) begin
      rsp_ready = 1'b0;
      i_wb_ack  = ($urandom_range(0, 1) == 1);
      cmd_valid = ($urandom_range(0, 1) == 1);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rdata", rsp_rdata, exp_rd);
      check("bp_err", rsp_err, tmo);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_cyc", o_wb_cyc, 0);
      @(negedge clk);
    end
    check("hs_rsp_valid", rsp_valid, 1);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    i_wb_ack  = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    i_wb_ack  = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_cmd_ready", cmd_ready, 1);
    check("post_cyc", o_wb_cyc, 0);
    check("post_addr", o_wb_addr, 0);
    check("post_rdata_held", rsp_rdata, exp_rd);
    check("post_err_held", rsp_err, tmo);
    i_wb_ack = 1'b1;
    @(negedge clk);
    i_wb_ack = 1'b0;
    check("late_ack_no_rsp", rsp_valid, 0);
    check("late_ack_no_cyc", o_wb_cyc, 0);
  endtask

  initial begin
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_we     = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    rsp_ready  = 1'b0;
    i_wb_ack   = 1'b0;
    i_wb_stall = 1'b0;
    i_wb_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_cyc", o_wb_cyc, 0);
    check("rst_stb", o_wb_stb, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    check("rst_sel", o_wb_sel, 0);
    reset_n = 1'b1;
    @(negedge clk);

    run_txn(1'b1, 32'h3000_0000, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1, 1'b1, 0);
    run_txn(1'b0, 32'h3000_0004, 32'h0, 32'h0000_0A5C, 3, 2, 1'b1, 0);
    run_txn(1'b0, 32'h3000_0008, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b1, 0);
    run_txn(1'b0, 32'h3000_000C, 32'h0, 32'h5555_AAAA, 0, 0, 1'b0, 0);
    run_txn(1'b0, 32'h3000_0010, 32'h0, 32'h0BAD_F00D, 0, 7, 1'b1, 0);
    run_txn(1'b0, 32'h3000_0014, 32'h0, 32'h0BAD_F00D, 0, 8, 1'b1, 0);
    run_txn(1'b0, 32'h3000_0018, 32'h0, 32'h1111_2222, 2, 5, 1'b1, 0);
    run_txn(1'b0, 32'h3000_001C, 32'h0, 32'h3333_4444, 9, 0, 1'b1, 0);
    run_txn(1'b1, 32'h3000_0020, 32'h7777_8888, 32'h9999_0000, 1, 1, 1'b1, 5);

    // Reset while waiting for an ack.
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 32'h3000_0100;
    @(negedge clk);
    cmd_valid  = 1'b0;
    i_wb_stall = 1'b0;
    i_wb_ack   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_wait_cyc", o_wb_cyc, 1);
    check("mid_wait_stb", o_wb_stb, 0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_cyc", o_wb_cyc, 0);
    check("async_rst_stb", o_wb_stb, 0);
    check("async_rst_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("after_rst_cmd_ready", cmd_ready, 1);
    check("after_rst_rsp_valid", rsp_valid, 0);
    run_txn(1'b0, 32'h3000_0104, 32'h0, 32'h600D_DA7A, 1, 2, 1'b1, 1);

    for (int t = 0; t < 80; t++) begin
      run_txn($urandom_range(0, 1) == 1, $urandom, $urandom, $urandom,
              $urandom_range(0, 9), $urandom_range(0, 9),
              $urandom_range(0, 4) != 0, $urandom_range(0, 5));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
